// File: rtl/digitallock_cpu_debug_mem_agent.sv
// Debug memory agent: turns JTAG debug-module strobes into single-word
// Avalon-MM reads/writes, with a bounded waitrequest timeout and drop tracking.
module digitallock_cpu_debug_mem_agent #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t        r_state, w_state;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] r_mon, w_mon;
    logic [DW-1:0] r_wdata, w_wdata;
    logic          r_read, w_read;
    logic          r_write, w_write;
    logic          r_ready, w_ready;
    logic          r_error, w_error;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_drop, w_drop;

    logic          w_any_strobe;
    logic          w_drop_now;
    logic [CW-1:0] w_cnt_inc;
    logic          w_unused_jdo;

    assign w_any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_drop_now   = r_drop | w_any_strobe;
    assign w_cnt_inc    = CW'(r_cnt + CW'(1));
    assign w_unused_jdo = ^{jdo[37], jdo[2:0]};

    // State and datapath registers; reset aborts any access immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_mon   <= '0;
            r_wdata <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_ready <= 1'b1;
            r_error <= 1'b0;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_mon   <= w_mon;
            r_wdata <= w_wdata;
            r_read  <= w_read;
            r_write <= w_write;
            r_ready <= w_ready;
            r_error <= w_error;
            r_cnt   <= w_cnt;
            r_drop  <= w_drop;
        end
    end

    // Next-state and next-register values; strobe priority is b > a > no_action_a.
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_mon   = r_mon;
        w_wdata = r_wdata;
        w_read  = r_read;
        w_write = r_write;
        w_ready = r_ready;
        w_error = r_error;
        w_cnt   = r_cnt;
        w_drop  = r_drop;

        case (r_state)
            S_IDLE: begin
                if (take_action_ocimem_b) begin
                    w_mon   = jdo[34:3];
                    w_wdata = jdo[34:3];
                    w_state = S_WR;
                    w_write = 1'b1;
                    w_ready = 1'b0;
                    w_error = 1'b0;
                    w_cnt   = '0;
                    w_drop  = 1'b0;
                end else if (take_action_ocimem_a) begin
                    w_addr  = jdo[35:6];
                    w_error = 1'b0;
                    w_cnt   = '0;
                    w_drop  = 1'b0;
                    if (jdo[36]) begin
                        w_state = S_RD;
                        w_read  = 1'b1;
                        w_ready = 1'b0;
                    end
                end else if (take_no_action_ocimem_a) begin
                    w_addr  = AW'(r_addr + AW'(1));
                    w_state = S_RD;
                    w_read  = 1'b1;
                    w_ready = 1'b0;
                    w_error = 1'b0;
                    w_cnt   = '0;
                    w_drop  = 1'b0;
                end
            end

            S_RD: begin
                w_drop = w_drop_now;
                if (!avm_waitrequest) begin
                    w_mon   = avm_readdata;
                    w_read  = 1'b0;
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                    w_error = w_drop_now;
                end else begin
                    w_cnt = w_cnt_inc;
                    if (w_cnt_inc == TIMEOUT_CNT) begin
                        w_read  = 1'b0;
                        w_state = S_IDLE;
                        w_ready = 1'b1;
                        w_error = 1'b1;
                    end
                end
            end

            S_WR: begin
                w_drop = w_drop_now;
                if (!avm_waitrequest) begin
                    w_addr  = AW'(r_addr + AW'(1));
                    w_write = 1'b0;
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                    w_error = w_drop_now;
                end else begin
                    w_cnt = w_cnt_inc;
                    if (w_cnt_inc == TIMEOUT_CNT) begin
                        w_write = 1'b0;
                        w_state = S_IDLE;
                        w_ready = 1'b1;
                        w_error = 1'b1;
                    end
                end
            end

            default: begin
                w_state = S_IDLE;
                w_read  = 1'b0;
                w_write = 1'b0;
                w_ready = 1'b1;
            end
        endcase
    end

    assign MonDReg       = r_mon;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;
    assign avm_address   = {r_addr, 2'b00};
    assign avm_read      = r_read;
    assign avm_write     = r_write;
    assign avm_writedata = r_wdata;

endmodule

// File: tb/tb_digitallock_cpu_debug_mem_agent.sv
// Directed bench for the debug memory agent, built with TIMEOUT=4.
module tb_digitallock_cpu_debug_mem_agent;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int n_cmp  = 0;
    int n_fail = 0;

    digitallock_cpu_debug_mem_agent #(.TIMEOUT(4)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] mk_a(input logic [29:0] addr, input logic rd);
        return {1'b0, rd, addr, 6'b0};
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        return {3'b0, data, 3'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and check read/write exclusivity.
    task automatic tick();
        @(posedge clk);
        #1;
        check("rw_excl", 32'(avm_read & avm_write), 32'd0);
    endtask

    initial begin
        reset_n                 = 1'b0;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        avm_readdata            = '0;
        avm_waitrequest         = 1'b0;

        // Reset values
        #12;
        check("rst_ready", 32'(monitor_ready), 32'd1);
        check("rst_error", 32'(monitor_error), 32'd0);
        check("rst_read",  32'(avm_read),      32'd0);
        check("rst_write", 32'(avm_write),     32'd0);
        check("rst_mon",   MonDReg,            32'd0);
        check("rst_addr",  avm_address,        32'd0);
        check("rst_wdata", avm_writedata,      32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Zero-wait read at word 0x10
        avm_readdata = 32'hDEADBEEF;
        jdo = mk_a(30'h10, 1'b1);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        check("rd1_read",  32'(avm_read),      32'd1);
        check("rd1_addr",  avm_address,        32'h40);
        check("rd1_busy",  32'(monitor_ready), 32'd0);
        tick();
        check("rd1_done",  32'(avm_read),      32'd0);
        check("rd1_ready", 32'(monitor_ready), 32'd1);
        check("rd1_mon",   MonDReg,            32'hDEADBEEF);
        check("rd1_err",   32'(monitor_error), 32'd0);

        // Write at 0x10, then increment-and-read
        jdo = mk_b(32'h12345678);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        check("wr1_write", 32'(avm_write),     32'd1);
        check("wr1_read",  32'(avm_read),      32'd0);
        check("wr1_addr",  avm_address,        32'h40);
        check("wr1_wdata", avm_writedata,      32'h12345678);
        check("wr1_mon",   MonDReg,            32'h12345678);
        tick();
        check("wr1_done",  32'(avm_write),     32'd0);
        check("wr1_ready", 32'(monitor_ready), 32'd1);
        check("wr1_inc",   avm_address,        32'h44);
        avm_readdata = 32'hCAFEF00D;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        check("rdn_read",  32'(avm_read),      32'd1);
        check("rdn_addr",  avm_address,        32'h48);
        tick();
        check("rdn_mon",   MonDReg,            32'hCAFEF00D);
        check("rdn_ready", 32'(monitor_ready), 32'd1);

        // Timeout: waitrequest stuck high, read held exactly 4 cycles
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h11111111;
        jdo = mk_a(30'h20, 1'b1);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_held", 32'(avm_read), 32'd1);
            tick();
        end
        check("to_read",  32'(avm_read),      32'd0);
        check("to_error", 32'(monitor_error), 32'd1);
        check("to_ready", 32'(monitor_ready), 32'd1);
        check("to_mon",   MonDReg,            32'hCAFEF00D);
        check("to_addr",  avm_address,        32'h80);
        avm_waitrequest = 1'b0;

        // Load without read clears error; then wrap 3FFFFFFF -> 0
        jdo = mk_a(30'h3FFFFFFF, 1'b0);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        check("ld_addr",  avm_address,        32'hFFFFFFFC);
        check("ld_ready", 32'(monitor_ready), 32'd1);
        check("ld_read",  32'(avm_read),      32'd0);
        check("ld_error", 32'(monitor_error), 32'd0);
        avm_readdata = 32'h0BADF00D;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        check("wrap_addr", avm_address,   32'h0);
        check("wrap_read", 32'(avm_read), 32'd1);
        tick();
        check("wrap_mon",  MonDReg,       32'h0BADF00D);

        // Simultaneous b and a: only the write happens
        jdo = mk_b(32'hA5A5A5A5);
        take_action_ocimem_b = 1'b1;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        take_action_ocimem_a = 1'b0;
        check("pri_write", 32'(avm_write), 32'd1);
        check("pri_read",  32'(avm_read),  32'd0);
        check("pri_addr",  avm_address,    32'h0);
        check("pri_wdata", avm_writedata,  32'hA5A5A5A5);
        tick();
        check("pri_err",   32'(monitor_error), 32'd0);
        check("pri_inc",   avm_address,        32'h4);

        // Strobe dropped during a 3-cycle-wait read
        avm_waitrequest = 1'b1;
        jdo = mk_a(30'h100, 1'b1);
        take_action_ocimem_a = 1'b1;
        tick();
        jdo = mk_a(30'h555, 1'b1);
        check("drop_read", 32'(avm_read), 32'd1);
        tick();
        take_action_ocimem_a = 1'b0;
        tick();
        tick();
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h76543210;
        check("drop_held", 32'(avm_read), 32'd1);
        tick();
        check("drop_mon",   MonDReg,            32'h76543210);
        check("drop_error", 32'(monitor_error), 32'd1);
        check("drop_ready", 32'(monitor_ready), 32'd1);
        check("drop_addr",  avm_address,        32'h400);

        // Reset during a stalled write
        avm_waitrequest = 1'b1;
        jdo = mk_b(32'h99999999);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        check("rw_write", 32'(avm_write), 32'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rw_abort", 32'(avm_write),     32'd0);
        check("rw_ready", 32'(monitor_ready), 32'd1);
        check("rw_error", 32'(monitor_error), 32'd0);
        check("rw_mon",   MonDReg,            32'd0);
        check("rw_addr",  avm_address,        32'd0);
        check("rw_wdata", avm_writedata,      32'd0);
        avm_waitrequest = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_ready", 32'(monitor_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/digitallock_cpu_debug_mem_agent.md
DIGITALLOCK_CPU_DEBUG_MEM_AGENT -- requirements
Module: digitallock_cpu_debug_mem_agent

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a bus strobe is held under waitrequest before the access is abandoned (range 1..255).
REQ-002 SHALL have port clk  in  1  the single system clock; all logic is in this domain.
REQ-003 SHALL have port reset_n  in  1  reset: asynchronous assert, active-low.
REQ-004 SHALL have port jdo  in  38  JTAG data word, already synchronised to clk by the upstream debug-module stage.
REQ-005 SHALL have port take_action_ocimem_a  in  1  one-cycle pulse: load address; optionally start a read.
REQ-006 SHALL have port take_no_action_ocimem_a  in  1  one-cycle pulse: increment address, then read.
REQ-007 SHALL have port take_action_ocimem_b  in  1  one-cycle pulse: write at the current address.
REQ-008 SHALL have port MonDReg  out  32  last read data or last written data, returned to the JTAG stage.
REQ-009 SHALL have port monitor_ready  out  1  1 = idle, access complete.
REQ-010 SHALL have port monitor_error  out  1  1 = last access timed out or a command was dropped.
REQ-011 SHALL have ports avm_address out 32, avm_read out 1, avm_write out 1, avm_writedata out 32, avm_readdata in 32, avm_waitrequest in 1, forming an Avalon-MM single-word master.

Function
REQ-012 SHALL hold a 30-bit word address register ADDR; avm_address = {ADDR, 2'b00}.
REQ-013 SHALL implement states IDLE, RD, WR; monitor_ready = 1 only in IDLE.
REQ-014 In IDLE, take_action_ocimem_a SHALL load ADDR <= jdo[35:6]; if jdo[36]=1, go to RD, otherwise stay in IDLE.
REQ-015 In IDLE, take_no_action_ocimem_a SHALL set ADDR <= ADDR+1 (modulo 2^30, 3FFFFFFF wraps to 0) and go to RD.
REQ-016 In IDLE, take_action_ocimem_b SHALL set MonDReg <= jdo[34:3] and avm_writedata <= jdo[34:3], then go to WR.
REQ-017 Simultaneous strobes in IDLE SHALL be prioritised b > a > no_action_a; lower-priority strobes are discarded without error.
REQ-018 Accepting any command SHALL clear monitor_error and the timeout counter in the same edge.
REQ-019 avm_read (RD) or avm_write (WR) SHALL be registered: asserted from the cycle after acceptance and held stable, with address and data, until waitrequest=0 or timeout.
REQ-020 On an RD cycle with avm_waitrequest=0, the block SHALL capture MonDReg <= avm_readdata, deassert avm_read, and return to IDLE; monitor_ready=1 on the next cycle.
REQ-021 On a WR cycle with avm_waitrequest=0, the block SHALL deassert avm_write, set ADDR <= ADDR+1, and return to IDLE.
REQ-022 An 8-bit counter SHALL increment on each RD/WR cycle with waitrequest=1. When it reaches TIMEOUT, the block SHALL deassert the strobe, set monitor_error=1, return to IDLE, and leave MonDReg and ADDR unchanged.
REQ-023 Any strobe arriving in RD/WR SHALL be ignored and SHALL set a drop flag. At completion, monitor_error = timeout OR drop.
REQ-024 Minimum latency SHALL be: command at edge N, strobe at edge N+1, and with no wait, monitor_ready=1 and MonDReg valid after edge N+2.
REQ-025 avm_read and avm_write SHALL never be asserted together.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state IDLE, ADDR=0, MonDReg=0, avm_writedata=0, avm_read=0, avm_write=0, monitor_ready=1, monitor_error=0, counter=0, and drop flag=0.
REQ-027 Reset asserted mid-access SHALL abort the access immediately (strobe low in the same cycle); no partial update of ADDR or MonDReg SHALL occur.

Verification
REQ-028 Read: ocimem_a with jdo[35:6]=0x0000_0010, jdo[36]=1, and slave returning 0xDEADBEEF with zero wait -> avm_address=0x40, MonDReg=0xDEADBEEF, monitor_ready high 2 cycles after the pulse.
REQ-029 Write then read-next: ocimem_b with jdo[34:3]=0x12345678 at ADDR=0x10 -> write to 0x40, ADDR=0x11; then no_action_a -> ADDR=0x12, read at 0x48.
REQ-030 Timeout: TIMEOUT=4, waitrequest stuck at 1 -> avm_read high exactly 4 cycles, then monitor_error=1, monitor_ready=1, MonDReg unchanged.
REQ-031 Wrap and priority: ADDR=0x3FFFFFFF with no_action_a -> read at 0x0; ocimem_b and ocimem_a pulsed in the same cycle -> only the write occurs, monitor_error=0.
REQ-032 Busy drop and reset: ocimem_a pulsed during a 3-cycle-wait read -> read completes with monitor_error=1; reset_n low during a WR with waitrequest=1 -> avm_write=0 immediately, all outputs at reset values.
